// File: rtl/smc_pulse_gen.sv
// Multi-channel stepper-motor pulse generator with a small register bus.
// Each channel emits HIGH/LOW step pulses on MNP (forward) or MNM (reverse).
module smc_pulse_gen #(
  parameter int NCH = 12,
  parameter int DW  = 16,
  parameter int AW  = 7
) (
  input  logic           QCLK,
  input  logic           QRESET,
  input  logic           QSEL,
  input  logic           QWRITE,
  input  logic [AW-1:0]  QADDR,
  input  logic [DW-1:0]  QDATAIN,
  output logic [DW-1:0]  QDATAOUT,
  output logic [NCH-1:0] MNP,
  output logic [NCH-1:0] MNM
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;

  state_e         state_q  [NCH];
  state_e         state_d  [NCH];
  logic [15:0]    period_q [NCH];
  logic [15:0]    period_d [NCH];
  logic [15:0]    steps_q  [NCH];
  logic [15:0]    steps_d  [NCH];
  logic [15:0]    phase_q  [NCH];
  logic [15:0]    phase_d  [NCH];
  logic [NCH-1:0] dir_q, dir_d, cont_q, cont_d, done_q, done_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic [AW-3:0]  ch_idx;
  logic [1:0]     reg_idx;
  logic [15:0]    wdata;
  logic [NCH-1:0] wsel;

  assign ch_idx   = QADDR[AW-1:2];
  assign reg_idx  = QADDR[1:0];
  assign wdata    = QDATAIN[15:0];
  assign QDATAOUT = rdata_q;

  // Out-of-range channel indices match no channel, so writes there fall away.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NCH; i++) begin
      wsel[i] = QSEL && QWRITE && (int'(ch_idx) == i);
    end
  end

  always_comb begin
    dir_d  = dir_q;
    cont_d = cont_q;
    done_d = done_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      steps_d[i]  = steps_q[i];
      phase_d[i]  = phase_q[i];

      // W1C clear comes before the FSM so a same-edge completion set wins.
      if (wsel[i] && reg_idx == 2'd3 && wdata[1]) begin
        done_d[i] = 1'b0;
      end

      case (state_q[i])
        HIGH: begin
          if (phase_q[i] <= 16'd1) begin
            state_d[i] = LOW;
            phase_d[i] = period_q[i];
          end else begin
            phase_d[i] = phase_q[i] - 16'd1;
          end
        end
        LOW: begin
          if (phase_q[i] <= 16'd1) begin
            phase_d[i] = period_q[i];
            if (cont_q[i]) begin
              state_d[i] = HIGH;
            end else begin
              steps_d[i] = steps_q[i] - 16'd1;
              if (steps_q[i] == 16'd1) begin
                state_d[i] = IDLE;
                done_d[i]  = 1'b1;
              end else begin
                state_d[i] = HIGH;
              end
            end
          end else begin
            phase_d[i] = phase_q[i] - 16'd1;
          end
        end
        default: ;
      endcase

      if (wsel[i]) begin
        case (reg_idx)
          2'd0: begin
            if (state_q[i] == IDLE) begin
              dir_d[i]  = wdata[2];
              cont_d[i] = wdata[3];
            end
            if (wdata[1]) begin
              // Stop aborts immediately, keeping the remaining count and DONE.
              state_d[i] = IDLE;
              steps_d[i] = steps_q[i];
              done_d[i]  = done_q[i];
            end else if (wdata[0] && state_q[i] == IDLE &&
                         (wdata[3] || steps_q[i] != 16'd0)) begin
              state_d[i] = HIGH;
              phase_d[i] = period_q[i];
            end
          end
          2'd1: period_d[i] = wdata;
          2'd2: if (state_q[i] == IDLE) steps_d[i] = wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (QSEL && !QWRITE) begin
      rdata_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (int'(ch_idx) == i) begin
          case (reg_idx)
            2'd0:    rdata_d[3:0]  = {cont_q[i], dir_q[i], 2'b00};
            2'd1:    rdata_d[15:0] = period_q[i];
            2'd2:    rdata_d[15:0] = steps_q[i];
            default: rdata_d[1:0]  = {done_q[i], state_q[i] != IDLE};
          endcase
        end
      end
    end
  end

  always_comb begin
    MNP = '0;
    MNM = '0;
    for (int i = 0; i < NCH; i++) begin
      MNP[i] = (state_q[i] == HIGH) && !dir_q[i];
      MNM[i] = (state_q[i] == HIGH) &&  dir_q[i];
    end
  end

  always_ff @(posedge QCLK or posedge QRESET) begin
    if (QRESET) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= IDLE;
        period_q[i] <= '0;
        steps_q[i]  <= '0;
        phase_q[i]  <= '0;
      end
      dir_q   <= '0;
      cont_q  <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        steps_q[i]  <= steps_d[i];
        phase_q[i]  <= phase_d[i];
      end
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_smc_pulse_gen.sv
// Directed bench for smc_pulse_gen: register table plus multi-cycle pulse sequences.
module tb_smc_pulse_gen;

  logic        QCLK = 1'b0;
  logic        QRESET, QSEL, QWRITE;
  logic [6:0]  QADDR;
  logic [15:0] QDATAIN;
  logic [15:0] QDATAOUT;
  logic [11:0] MNP, MNM;

  int n_cmp = 0;
  int n_bad = 0;

  smc_pulse_gen #(.NCH(12), .DW(16), .AW(7)) dut (
    .QCLK(QCLK), .QRESET(QRESET), .QSEL(QSEL), .QWRITE(QWRITE),
    .QADDR(QADDR), .QDATAIN(QDATAIN), .QDATAOUT(QDATAOUT),
    .MNP(MNP), .MNM(MNM)
  );

  always #5 QCLK = ~QCLK;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [15:0] d);
    @(negedge QCLK);
    QSEL = 1'b1; QWRITE = 1'b1; QADDR = a; QDATAIN = d;
    @(posedge QCLK); #1;
    QSEL = 1'b0; QWRITE = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, output logic [15:0] d);
    @(negedge QCLK);
    QSEL = 1'b1; QWRITE = 1'b0; QADDR = a;
    @(posedge QCLK); #1;
    d = QDATAOUT;
    QSEL = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    QRESET = 1'b1; QSEL = 1'b0; QWRITE = 1'b0; QADDR = '0; QDATAIN = '0;
    repeat (3) @(posedge QCLK);
    #1;
    chk("reset_mnp", MNP, 0);
    chk("reset_mnm", MNM, 0);
    chk("reset_qdataout", QDATAOUT, 0);
    @(negedge QCLK); QRESET = 1'b0;
    bus_rd(7'h01, rd); chk("reset_ch0_period", rd, 16'h0000);

    // Register map table: {write?, addr, wdata, expected read}
    tbl.push_back('{1'b1, 7'h01, 16'hBEEF, 16'h0000, "wr_ch0_period"});
    tbl.push_back('{1'b0, 7'h01, 16'h0000, 16'hBEEF, "rd_ch0_period"});
    tbl.push_back('{1'b1, 7'h0E, 16'h0007, 16'h0000, "wr_ch3_steps"});
    tbl.push_back('{1'b0, 7'h0E, 16'h0000, 16'h0007, "rd_ch3_steps"});
    tbl.push_back('{1'b1, 7'h0C, 16'hFFFC, 16'h0000, "wr_ch3_ctrl"});
    tbl.push_back('{1'b0, 7'h0C, 16'h0000, 16'h000C, "rd_ch3_ctrl"});
    tbl.push_back('{1'b0, 7'h0F, 16'h0000, 16'h0000, "rd_ch3_status"});
    tbl.push_back('{1'b1, 7'h31, 16'h1234, 16'h0000, "wr_ch12_oor"});
    tbl.push_back('{1'b0, 7'h31, 16'h0000, 16'h0000, "rd_ch12_oor"});
    tbl.push_back('{1'b0, 7'h01, 16'h0000, 16'hBEEF, "rd_ch0_after_oor"});
    tbl.push_back('{1'b1, 7'h2D, 16'h5555, 16'h0000, "wr_ch11_period"});
    tbl.push_back('{1'b0, 7'h2D, 16'h0000, 16'h5555, "rd_ch11_period"});
    tbl.push_back('{1'b0, 7'h29, 16'h0000, 16'h0000, "rd_ch10_period"});
    tbl.push_back('{1'b1, 7'h0C, 16'h0000, 16'h0000, "wr_ch3_ctrl_clr"});
    tbl.push_back('{1'b0, 7'h0C, 16'h0000, 16'h0000, "rd_ch3_ctrl_clr"});
    tbl.push_back('{1'b0, 7'h0E, 16'h0000, 16'h0007, "rd_ch3_steps_again"});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
      else begin
        bus_rd(tbl[i].addr, rd);
        chk(tbl[i].name, rd, tbl[i].exp);
      end
    end
    chk("idle_outputs", {MNP, MNM}, 0);

    // Finite run on ch0 with STATUS polled every cycle
    bus_wr(7'h01, 16'd3);
    bus_wr(7'h02, 16'd2);
    @(negedge QCLK);
    QSEL = 1'b1; QWRITE = 1'b1; QADDR = 7'h00; QDATAIN = 16'h0001;
    @(posedge QCLK); #1;
    chk("fin_mnp_k0", MNP[0], 1'b1);
    QWRITE = 1'b0; QADDR = 7'h03;
    for (int k = 1; k <= 13; k++) begin
      @(posedge QCLK); #1;
      chk($sformatf("fin_mnp_k%0d", k), MNP[0], (k < 12) && ((k % 6) < 3));
      chk($sformatf("fin_status_k%0d", k), QDATAOUT, (k <= 12) ? 16'h0001 : 16'h0002);
    end
    QSEL = 1'b0;
    chk("fin_mnm_never", MNM[0], 1'b0);
    bus_rd(7'h02, rd); chk("fin_steps_left", rd, 16'h0000);
    bus_wr(7'h03, 16'h0002);
    bus_rd(7'h03, rd); chk("fin_done_w1c", rd, 16'h0000);

    // Continuous reverse run on ch5, then STOP
    bus_wr(7'h15, 16'd0);
    bus_wr(7'h14, 16'h000D);
    chk("cont_mnm_k0", MNM[5], 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge QCLK); #1;
      chk($sformatf("cont_mnm_k%0d", k), MNM[5], (k % 2) == 0);
      chk($sformatf("cont_mnp_k%0d", k), MNP[5], 1'b0);
    end
    bus_wr(7'h14, 16'h0002);
    chk("stop_mnm_edge", MNM[5], 1'b0);
    repeat (3) @(posedge QCLK);
    #1;
    chk("stop_mnm_after", MNM[5], 1'b0);
    bus_rd(7'h17, rd); chk("stop_status", rd, 16'h0000);

    // START and STOP together on ch2
    bus_wr(7'h0A, 16'd5);
    bus_wr(7'h08, 16'h0003);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ss_pulse_k%0d", k), {MNP[2], MNM[2]}, 2'b00);
      @(posedge QCLK); #1;
    end
    bus_rd(7'h0B, rd); chk("ss_status", rd, 16'h0000);
    bus_rd(7'h0A, rd); chk("ss_steps", rd, 16'd5);

    // Reset in the middle of a ch1 run
    bus_wr(7'h05, 16'd10);
    bus_wr(7'h06, 16'd4);
    bus_wr(7'h04, 16'h0001);
    repeat (3) @(posedge QCLK);
    #2;
    chk("rr_mnp_before", MNP[1], 1'b1);
    QRESET = 1'b1;
    #1;
    chk("rr_mnp_async", MNP[1], 1'b0);
    chk("rr_qdataout_async", QDATAOUT, 16'h0000);
    @(negedge QCLK); QRESET = 1'b0;
    repeat (4) @(posedge QCLK);
    #1;
    chk("rr_outputs_after", {MNP, MNM}, 0);
    bus_rd(7'h07, rd); chk("rr_status", rd, 16'h0000);
    bus_rd(7'h06, rd); chk("rr_steps", rd, 16'h0000);
    bus_rd(7'h05, rd); chk("rr_period", rd, 16'h0000);
    bus_rd(7'h03, rd); chk("rr_ch0_status", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
